// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-stage instruction words in, stall/flush/busy/perf status out
interface hazard_stall_ctrl_if;
    logic [31:0] instrD;
    logic [31:0] instrE;
    logic [31:0] instrM;
    logic        stall;
    logic        flush_E;
    logic        md_busy;
    logic [31:0] stall_cycles;

    modport master (
        output instrD, instrE, instrM,
        input  stall, flush_E, md_busy, stall_cycles
    );

    modport slave (
        input  instrD, instrE, instrM,
        output stall, flush_E, md_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - MIPS hazard stall/flush controller with mult/div busy window
// Optional stall performance counter enabled by defining STALL_PERF_CNT_EN.
module hctrl (
    input  logic [31:0] instr_i,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  dst_o,
    output logic        load_o,
    output logic        store_o,
    output logic        cal_i_o,
    output logic        cal_r_o,
    output logic        b_type_o,
    output logic        jr_o,
    output logic        jal_o,
    output logic        mult_o,
    output logic        div_o,
    output logic        md_use_o
);
    logic [5:0] op;
    logic [5:0] funct;
    logic       hilo_only;
    logic       unused_shamt;

    assign op           = instr_i[31:26];
    assign funct        = instr_i[5:0];
    assign rs_o         = instr_i[25:21];
    assign rt_o         = instr_i[20:16];
    assign unused_shamt = ^instr_i[10:6];

    always_comb begin
        load_o    = 1'b0;
        store_o   = 1'b0;
        cal_i_o   = 1'b0;
        cal_r_o   = 1'b0;
        b_type_o  = 1'b0;
        jr_o      = 1'b0;
        jal_o     = 1'b0;
        mult_o    = 1'b0;
        div_o     = 1'b0;
        hilo_only = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h08:        jr_o      = 1'b1;
                    6'h18, 6'h19: mult_o    = 1'b1;
                    6'h1a, 6'h1b: div_o     = 1'b1;
                    6'h11, 6'h13: hilo_only = 1'b1;
                    // mfhi/mflo write rd like any R-type and also touch HI/LO
                    6'h10, 6'h12: begin
                        cal_r_o   = 1'b1;
                        hilo_only = 1'b1;
                    end
                    default:      cal_r_o   = 1'b1;
                endcase
            end
            6'h03:                             jal_o    = 1'b1;
            6'h04, 6'h05, 6'h06, 6'h07:        b_type_o = 1'b1;
            6'h08, 6'h09, 6'h0a, 6'h0b,
            6'h0c, 6'h0d, 6'h0e, 6'h0f:        cal_i_o  = 1'b1;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: load_o   = 1'b1;
            6'h28, 6'h29, 6'h2b:               store_o  = 1'b1;
            default: ;
        endcase
        md_use_o = hilo_only | mult_o | div_o;
        // jal's $31 write is always bypassed, so it never names a destination here
        if (load_o || cal_i_o)
            dst_o = instr_i[20:16];
        else if (cal_r_o)
            dst_o = instr_i[15:11];
        else
            dst_o = 5'd0;
    end
endmodule

module hazard_stall_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic           clk,
    input  logic           reset,
    hazard_stall_ctrl_if.slave bus
);
    logic [4:0] rs_d, rt_d, dst_d_unused, rs_e, rt_e, dst_e, rs_m, rt_m, dst_m;
    logic load_d, store_d, cal_i_d, cal_r_d, b_d, jr_d, jal_d, mult_d, div_d, mdu_d;
    logic load_e, store_e, cal_i_e, cal_r_e, b_e, jr_e, jal_e, mult_e, div_e, mdu_e;
    logic load_m, store_m, cal_i_m, cal_r_m, b_m, jr_m, jal_m, mult_m, div_m, mdu_m;

    hctrl u_dec_d (.instr_i(bus.instrD), .rs_o(rs_d), .rt_o(rt_d), .dst_o(dst_d_unused),
        .load_o(load_d), .store_o(store_d), .cal_i_o(cal_i_d), .cal_r_o(cal_r_d),
        .b_type_o(b_d), .jr_o(jr_d), .jal_o(jal_d), .mult_o(mult_d), .div_o(div_d),
        .md_use_o(mdu_d));
    hctrl u_dec_e (.instr_i(bus.instrE), .rs_o(rs_e), .rt_o(rt_e), .dst_o(dst_e),
        .load_o(load_e), .store_o(store_e), .cal_i_o(cal_i_e), .cal_r_o(cal_r_e),
        .b_type_o(b_e), .jr_o(jr_e), .jal_o(jal_e), .mult_o(mult_e), .div_o(div_e),
        .md_use_o(mdu_e));
    hctrl u_dec_m (.instr_i(bus.instrM), .rs_o(rs_m), .rt_o(rt_m), .dst_o(dst_m),
        .load_o(load_m), .store_o(store_m), .cal_i_o(cal_i_m), .cal_r_o(cal_r_m),
        .b_type_o(b_m), .jr_o(jr_m), .jal_o(jal_m), .mult_o(mult_m), .div_o(div_m),
        .md_use_o(mdu_m));

    logic unused_dec;
    assign unused_dec = ^{dst_d_unused, jal_d, mult_d, div_d, rs_e, rt_e, store_e, b_e,
                          jr_e, jal_e, mdu_e, rs_m, rt_m, store_m, cal_i_m, cal_r_m, b_m,
                          jr_m, jal_m, mult_m, div_m, mdu_m};

    logic [3:0] md_cnt_q, md_cnt_d;
    logic       md_op_e, hit_rs_e, hit_rt_e, hit_rs_m, hit_rt_m;
    logic       s1, s2, s3, s4, stall;

    assign md_op_e = mult_e | div_e;
    assign bus.md_busy = (md_cnt_q != 4'd0);

    // Register 0 is excluded by requiring a nonzero destination on every match
    assign hit_rs_e = (dst_e != 5'd0) && (dst_e == rs_d);
    assign hit_rt_e = (dst_e != 5'd0) && (dst_e == rt_d);
    assign hit_rs_m = (dst_m != 5'd0) && (dst_m == rs_d);
    assign hit_rt_m = (dst_m != 5'd0) && (dst_m == rt_d);

    assign s1 = (b_d | jr_d) && (load_e | cal_i_e | cal_r_e) && (hit_rs_e || (b_d && hit_rt_e));
    assign s2 = (b_d | jr_d) && load_m && (hit_rs_m || (b_d && hit_rt_m));
    assign s3 = load_e && ((hit_rs_e && (cal_i_d | cal_r_d | load_d | store_d)) ||
                           (hit_rt_e && cal_r_d));
    assign s4 = mdu_d && (bus.md_busy || md_op_e);

    assign stall       = (s1 | s2 | s3 | s4) & ~reset;
    assign bus.stall   = stall;
    assign bus.flush_E = stall;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (div_e)
            md_cnt_d = DIV_CYC[3:0];
        else if (mult_e)
            md_cnt_d = MULT_CYC[3:0];
        else if (md_cnt_q != 4'd0)
            md_cnt_d = md_cnt_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            md_cnt_q <= 4'd0;
        else
            md_cnt_q <= md_cnt_d;
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles_q <= 32'd0;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign bus.stall_cycles = stall_cycles_q;
`else
    assign bus.stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   exp_cyc = 0;

    hazard_stall_ctrl_if bus ();
    hazard_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [31:0] NOP       = 32'h0;
    localparam logic [31:0] ADDU_3_24 = {6'h00, 5'd2, 5'd4, 5'd3, 5'd0, 6'h21};
    localparam logic [31:0] ADDU_3_04 = {6'h00, 5'd0, 5'd4, 5'd3, 5'd0, 6'h21};
    localparam logic [31:0] LW_2      = {6'h23, 5'd1, 5'd2, 16'h0};
    localparam logic [31:0] LW_0      = {6'h23, 5'd1, 5'd0, 16'h0};
    localparam logic [31:0] LW_7      = {6'h23, 5'd1, 5'd7, 16'h0};
    localparam logic [31:0] ADDU_7    = {6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h21};
    localparam logic [31:0] JR_31     = {6'h00, 5'd31, 15'h0, 6'h08};
    localparam logic [31:0] JR_5      = {6'h00, 5'd5, 15'h0, 6'h08};
    localparam logic [31:0] JAL       = {6'h03, 26'h10};
    localparam logic [31:0] ADDIU_5   = {6'h09, 5'd5, 5'd5, 16'd1};
    localparam logic [31:0] BEQ_67    = {6'h04, 5'd6, 5'd7, 16'd4};
    localparam logic [31:0] DIV_89    = {6'h00, 5'd8, 5'd9, 10'h0, 6'h1a};
    localparam logic [31:0] MULT_89   = {6'h00, 5'd8, 5'd9, 10'h0, 6'h18};
    localparam logic [31:0] MFLO_10   = {6'h00, 10'h0, 5'd10, 5'd0, 6'h12};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, exp});
        chk({tag, ".flush"}, {31'd0, bus.flush_E}, {31'd0, exp});
        if (exp && !reset) exp_cyc++;
    endtask

    task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
        bus.instrD = d;
        bus.instrE = e;
        bus.instrM = m;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_perf(input string tag);
`ifdef STALL_PERF_CNT_EN
        chk(tag, bus.stall_cycles, exp_cyc);
`else
        chk(tag, bus.stall_cycles, 32'd0);
`endif
    endtask

    initial begin
        drive(NOP, NOP, NOP);
        step();
        drive(ADDU_3_24, LW_2, NOP);
        @(negedge clk);
        chk_stall("rst_hold", 1'b0);
        chk("rst_busy", {31'd0, bus.md_busy}, 32'd0);
        chk("rst_perf", bus.stall_cycles, 32'd0);
        step();
        reset = 1'b0;
        drive(NOP, NOP, NOP);
        @(negedge clk);
        chk_stall("idle", 1'b0);
        chk("idle_busy", {31'd0, bus.md_busy}, 32'd0);

        // load-use then bubble
        step();
        drive(ADDU_3_24, LW_2, NOP);
        @(negedge clk);
        chk_stall("lduse", 1'b1);
        step();
        drive(ADDU_3_24, NOP, LW_2);
        @(negedge clk);
        chk_stall("lduse_after", 1'b0);

        step();
        drive(ADDU_3_04, LW_0, NOP);
        @(negedge clk);
        chk_stall("reg0", 1'b0);

        step();
        drive(JR_31, JAL, NOP);
        @(negedge clk);
        chk_stall("jr_jal", 1'b0);
        step();
        drive(JR_5, ADDIU_5, NOP);
        @(negedge clk);
        chk_stall("jr_addiu", 1'b1);

        step();
        drive(BEQ_67, NOP, LW_7);
        @(negedge clk);
        chk_stall("beq_mlw", 1'b1);
        step();
        drive(BEQ_67, NOP, ADDU_7);
        @(negedge clk);
        chk_stall("beq_maddu", 1'b0);
        step();
        drive(BEQ_67, ADDU_7, NOP);
        @(negedge clk);
        chk_stall("beq_eaddu", 1'b1);
        chk_perf("perf_mid");

        // divide busy window with mflo waiting in D
        step();
        drive(MFLO_10, DIV_89, NOP);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk_stall($sformatf("div_%0d", i), 1'b1);
            chk($sformatf("div_busy_%0d", i), {31'd0, bus.md_busy}, {31'd0, (i != 0)});
            step();
            drive(MFLO_10, NOP, NOP);
        end
        @(negedge clk);
        chk_stall("div_release", 1'b0);
        chk("div_release_busy", {31'd0, bus.md_busy}, 32'd0);

        step();
        drive(MFLO_10, MULT_89, NOP);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_stall($sformatf("mult_%0d", i), 1'b1);
            step();
            drive(MFLO_10, NOP, NOP);
        end
        @(negedge clk);
        chk_stall("mult_release", 1'b0);
        chk("mult_release_busy", {31'd0, bus.md_busy}, 32'd0);
        chk_perf("perf_md");

        // reset in the middle of a mult window
        step();
        drive(NOP, MULT_89, NOP);
        step();
        drive(NOP, NOP, NOP);
        step();
        step();
        @(negedge clk);
        chk("mid_cnt3", {28'd0, dut.md_cnt_q}, 32'd3);
        step();
        reset = 1'b1;
        step();
        exp_cyc = 0;
        @(negedge clk);
        chk("rst_cnt", {28'd0, dut.md_cnt_q}, 32'd0);
        chk("rst_mid_busy", {31'd0, bus.md_busy}, 32'd0);
        chk("rst_mid_perf", bus.stall_cycles, 32'd0);
        step();
        reset = 1'b0;
        drive(MFLO_10, NOP, NOP);
        @(negedge clk);
        chk_stall("post_rst", 1'b0);

        for (int i = 0; i < 3; i++) begin
            step();
            drive(ADDU_3_24, LW_2, NOP);
            @(negedge clk);
            chk_stall($sformatf("perf_lu_%0d", i), 1'b1);
            step();
            drive(NOP, NOP, NOP);
        end
        @(negedge clk);
        chk_perf("perf_three");
`ifdef STALL_PERF_CNT_EN
        chk("perf_three_abs", bus.stall_cycles, 32'd3);
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        step();
        drive(ADDU_3_24, LW_2, NOP);
        @(negedge clk);
        chk_stall("sat_stall", 1'b1);
        step();
        drive(NOP, NOP, NOP);
        @(negedge clk);
        chk("perf_sat", bus.stall_cycles, 32'hFFFF_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
